lsu_mem_port: RTL and testbench

Load/store initiator between the single-cycle core's execute stage and the data-memory port. It accepts one load or store request at a time using the core's 3-bit memory-op encoding. It converts the request into a word-aligned memory bus transaction with byte strobes, then extracts, shifts and sign- or zero-extends the returned data. Misaligned and illegal requests are faulted locally. A response timeout guards against a hung memory.

---
 rtl/lsu_pkg.sv | 27 ++
 rtl/lsu_mem_port_lane.sv | 47 ++++
 rtl/lsu_mem_port.sv | 123 ++++++++++++
 tb/tb_lsu_mem_port.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store memory port: op encodings, FSM states
// and request legality checks.
package lsu_pkg;

    localparam logic [2:0] LSU_LB  = 3'b000;
    localparam logic [2:0] LSU_LH  = 3'b001;
    localparam logic [2:0] LSU_LW  = 3'b010;
    localparam logic [2:0] LSU_LBU = 3'b100;
    localparam logic [2:0] LSU_LHU = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } lsu_state_e;

    function automatic logic lsu_op_illegal(input logic [2:0] op);
        return !(op inside {LSU_LB, LSU_LH, LSU_LW, LSU_LBU, LSU_LHU});
    endfunction

    // op[1:0] is the access size: 00 byte, 01 half, 10 word.
    function automatic logic lsu_misaligned(input logic [2:0] op, input logic [1:0] off);
        return ((op[1:0] == 2'b01) && off[0]) || ((op[1:0] == 2'b10) && (off != 2'b00));
    endfunction

endpackage

// File: rtl/lsu_mem_port_lane.sv
// Byte-lane steering: store strobe/data placement and load extract/extend.
// Purely combinational so it can be reused and unit-tested on its own.
module lsu_lane
    import lsu_pkg::*;
(
    input  logic [2:0]  i_op,
    input  logic [1:0]  i_off,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_rdata,
    output logic [3:0]  o_wstrb,
    output logic [31:0] o_wdata,
    output logic [31:0] o_rdata
);

    logic [4:0]  w_shamt;
    logic [31:0] w_lane;
    logic        w_sext;

    assign w_shamt = {i_off, 3'b000};
    assign w_lane  = i_rdata >> w_shamt;
    assign w_sext  = ~i_op[2];

    always_comb begin
        // NOTE: every output gets a default before the case, so no path can infer a latch.
        o_wstrb = '0;
        o_wdata = '0;
        o_rdata = '0;
        case (i_op[1:0])
            2'b00: begin
                o_wstrb = 4'b0001 << i_off;
                o_wdata = {24'b0, i_wdata[7:0]} << w_shamt;
                o_rdata = {{24{w_sext & w_lane[7]}}, w_lane[7:0]};
            end
            2'b01: begin
                o_wstrb = 4'b0011 << i_off;
                o_wdata = {16'b0, i_wdata[15:0]} << w_shamt;
                o_rdata = {{16{w_sext & w_lane[15]}}, w_lane[15:0]};
            end
            default: begin
                o_wstrb = 4'b1111;
                o_wdata = i_wdata;
                o_rdata = i_rdata;
            end
        endcase
    end

endmodule

// File: rtl/lsu_mem_port.sv
// Load/store initiator: one request at a time, word-aligned bus transaction,
// local fault on misalignment/illegal op, response timeout against a hung memory.
module lsu_mem_port
    import lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_op,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_valid,
    input  logic        mem_ready,
    output logic [31:0] mem_addr,
    output logic        mem_we,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_wdata,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);

    lsu_state_e  r_state;
    lsu_state_e  w_next;
    logic        r_we;
    logic [2:0]  r_op;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [15:0] r_cnt;
    logic [31:0] r_resp_rdata;
    logic        r_resp_err;

    logic        w_fault;
    logic        w_timeout;
    logic        w_store;
    logic [3:0]  w_wstrb;
    logic [31:0] w_wdata_sh;
    logic [31:0] w_rdata_ext;

    assign w_fault   = lsu_op_illegal(req_op) | lsu_misaligned(req_op, req_addr[1:0]);
    // Fires on the cycle whose increment would bring the count to TIMEOUT.
    assign w_timeout = (({1'b0, r_cnt} + 17'd1) == 17'(TIMEOUT));

    lsu_lane u_lane (
        .i_op    (r_op),
        .i_off   (r_addr[1:0]),
        .i_wdata (r_wdata),
        .i_rdata (mem_rdata),
        .o_wstrb (w_wstrb),
        .o_wdata (w_wdata_sh),
        .o_rdata (w_rdata_ext)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (req_valid) w_next = w_fault ? S_RESP : S_ISSUE;
            S_ISSUE: if (w_timeout) w_next = S_RESP;
                     else if (mem_ready) w_next = S_WAIT;
            S_WAIT:  if (mem_rvalid || w_timeout) w_next = S_RESP;
            default: w_next = S_IDLE;
        endcase
    end

    assign req_ready  = (r_state == S_IDLE);
    assign resp_valid = (r_state == S_RESP);
    assign resp_rdata = r_resp_rdata;
    assign resp_err   = r_resp_err;
    assign mem_valid  = (r_state == S_ISSUE);
    assign w_store    = mem_valid & r_we;
    assign mem_addr   = mem_valid ? {r_addr[31:2], 2'b00} : '0;
    assign mem_we     = w_store;
    assign mem_wstrb  = w_store ? w_wstrb : '0;
    assign mem_wdata  = w_store ? w_wdata_sh : '0;

    // NOTE: all sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_we         <= 1'b0;
            r_op         <= '0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_cnt        <= '0;
            r_resp_rdata <= '0;
            r_resp_err   <= 1'b0;
        end else begin
            if (req_ready && req_valid) begin
                r_we    <= req_we;
                r_op    <= req_op;
                r_addr  <= req_addr;
                r_wdata <= req_wdata;
                r_cnt   <= '0;
            end else if (r_state inside {S_ISSUE, S_WAIT}) begin
                r_cnt <= r_cnt + 16'd1;
            end

            // Response fields are zero except in the single RESP cycle.
            r_resp_rdata <= '0;
            r_resp_err   <= 1'b0;
            case (r_state)
                S_IDLE:  if (req_valid && w_fault) r_resp_err <= 1'b1;
                S_ISSUE: if (w_timeout) r_resp_err <= 1'b1;
                S_WAIT: begin
                    if (mem_rvalid)     r_resp_rdata <= r_we ? '0 : w_rdata_ext;
                    else if (w_timeout) r_resp_err   <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_mem_port.sv
// Self-checking bench for lsu_mem_port: table-driven transactions with a response
// scoreboard, plus hand-written timeout and reset sequences.
module tb_lsu_mem_port;
    import lsu_pkg::*;

    typedef struct {
        logic        we;
        logic [2:0]  op;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          rdy_dly;
        int          rv_dly;
        logic        fault;
        logic [3:0]  strb;
        logic [31:0] mwdata;
        logic [31:0] exp_rdata;
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          cyc;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_we;
    logic [2:0]  req_op;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        mem_ready;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    logic        req_ready, resp_valid, resp_err, mem_valid, mem_we;
    logic [31:0] resp_rdata, mem_addr, mem_wdata;
    logic [3:0]  mem_wstrb;

    logic        t_req_ready, t_resp_valid, t_resp_err, t_mem_valid, t_mem_we;
    logic [31:0] t_resp_rdata, t_mem_addr, t_mem_wdata;
    logic [3:0]  t_mem_wstrb;

    int   n_checks = 0;
    int   n_errs   = 0;
    int   cyc      = 0;
    logic en2      = 1'b0;
    exp_t q[$];
    exp_t q2[$];
    vec_t vecs[$];

    lsu_mem_port #(.TIMEOUT(16)) u_dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_op(req_op),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_we(mem_we),
        .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    lsu_mem_port #(.TIMEOUT(4)) u_dut_to (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(t_req_ready), .req_we(req_we), .req_op(req_op),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(t_resp_valid), .resp_rdata(t_resp_rdata), .resp_err(t_resp_err),
        .mem_valid(t_mem_valid), .mem_ready(mem_ready), .mem_addr(t_mem_addr), .mem_we(t_mem_we),
        .mem_wstrb(t_mem_wstrb), .mem_wdata(t_mem_wdata),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Response scoreboards, sampled on the falling edge.
    always @(negedge clk) begin
        if (resp_valid) begin
            if (q.size() == 0) begin
                check("dut resp_valid with nothing expected", 32'(resp_valid), 32'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("dut resp_rdata", resp_rdata, e.rdata);
                check("dut resp_err", 32'(resp_err), 32'(e.err));
                check("dut resp cycle", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    always @(negedge clk) begin
        if (en2 && t_resp_valid) begin
            if (q2.size() == 0) begin
                check("to resp_valid with nothing expected", 32'(t_resp_valid), 32'd0);
            end else begin
                exp_t e;
                e = q2.pop_front();
                check("to resp_rdata", t_resp_rdata, e.rdata);
                check("to resp_err", 32'(t_resp_err), 32'(e.err));
                check("to resp cycle", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, " req_ready"},  32'(req_ready),  32'd1);
        check({tag, " resp_valid"}, 32'(resp_valid), 32'd0);
        check({tag, " resp_rdata"}, resp_rdata,      32'd0);
        check({tag, " resp_err"},   32'(resp_err),   32'd0);
        check({tag, " mem_valid"},  32'(mem_valid),  32'd0);
        check({tag, " mem_addr"},   mem_addr,        32'd0);
        check({tag, " mem_we"},     32'(mem_we),     32'd0);
        check({tag, " mem_wstrb"},  32'(mem_wstrb),  32'd0);
        check({tag, " mem_wdata"},  mem_wdata,       32'd0);
    endtask

    // Called at a falling edge with the DUT idle; returns at a falling edge with it idle again.
    task automatic do_txn(input vec_t v);
        int   n;
        exp_t e;
        n = cyc;
        check("req_ready before accept", 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_we    = v.we;
        req_op    = v.op;
        req_addr  = v.addr;
        req_wdata = v.wdata;
        e.rdata = v.exp_rdata;
        e.err   = v.fault;
        e.cyc   = n + (v.fault ? 1 : 3 + v.rdy_dly + v.rv_dly);
        q.push_back(e);
        if (en2) q2.push_back(e);
        @(negedge clk);
        req_valid = 1'b0;
        req_we    = 1'($urandom);
        req_op    = 3'($urandom);
        req_addr  = $urandom;
        req_wdata = $urandom;
        if (v.fault) begin
            check("no mem_valid on fault", 32'(mem_valid), 32'd0);
            check("req_ready low in fault resp", 32'(req_ready), 32'd0);
        end else begin
            for (int i = 0; i <= v.rdy_dly; i++) begin
                check("mem_valid in issue", 32'(mem_valid), 32'd1);
                check("mem_addr", mem_addr, {v.addr[31:2], 2'b00});
                check("mem_we", 32'(mem_we), 32'(v.we));
                check("mem_wstrb", 32'(mem_wstrb), 32'(v.strb));
                check("mem_wdata", mem_wdata, v.mwdata);
                check("req_ready low in issue", 32'(req_ready), 32'd0);
                mem_ready = (i == v.rdy_dly);
                @(negedge clk);
            end
            mem_ready = 1'b0;
            for (int i = 0; i <= v.rv_dly; i++) begin
                check("mem_valid low in wait", 32'(mem_valid), 32'd0);
                check("req_ready low in wait", 32'(req_ready), 32'd0);
                mem_rvalid = (i == v.rv_dly);
                mem_rdata  = (i == v.rv_dly) ? v.rdata : $urandom;
                @(negedge clk);
            end
            mem_rvalid = 1'b0;
            check("req_ready low in resp", 32'(req_ready), 32'd0);
        end
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int   n;
        vec_t v;

        // {we, op, addr, wdata, rdata, rdy_dly, rv_dly, fault, strb, mwdata, exp_rdata}
        vecs.push_back('{1'b0, LSU_LB,  32'h8000_0003, 32'h0,         32'h80FF_0000, 0, 0, 1'b0, 4'b0000, 32'h0,         32'hFFFF_FF80});
        vecs.push_back('{1'b0, LSU_LBU, 32'h8000_0003, 32'h0,         32'h80FF_0000, 0, 0, 1'b0, 4'b0000, 32'h0,         32'h0000_0080});
        vecs.push_back('{1'b1, LSU_LH,  32'h0000_1002, 32'h1234_ABCD, 32'hFFFF_FFFF, 0, 0, 1'b0, 4'b1100, 32'hABCD_0000, 32'h0});
        vecs.push_back('{1'b0, LSU_LW,  32'h0000_1001, 32'h0,         32'h0,         0, 0, 1'b1, 4'b0000, 32'h0,         32'h0});
        vecs.push_back('{1'b0, LSU_LH,  32'h0000_1003, 32'h0,         32'h0,         0, 0, 1'b1, 4'b0000, 32'h0,         32'h0});
        vecs.push_back('{1'b0, 3'b011,  32'h0000_1000, 32'h0,         32'h0,         0, 0, 1'b1, 4'b0000, 32'h0,         32'h0});
        vecs.push_back('{1'b0, LSU_LH,  32'h0000_2002, 32'h0,         32'h8001_7FFF, 0, 0, 1'b0, 4'b0000, 32'h0,         32'hFFFF_8001});
        vecs.push_back('{1'b0, LSU_LHU, 32'h0000_2000, 32'h0,         32'h8001_F00F, 0, 0, 1'b0, 4'b0000, 32'h0,         32'h0000_F00F});
        vecs.push_back('{1'b0, LSU_LW,  32'h0000_3000, 32'h0,         32'hCAFE_F00D, 2, 1, 1'b0, 4'b0000, 32'h0,         32'hCAFE_F00D});
        vecs.push_back('{1'b0, LSU_LB,  32'h0000_8001, 32'h0,         32'h0000_FE00, 0, 0, 1'b0, 4'b0000, 32'h0,         32'hFFFF_FFFE});
        vecs.push_back('{1'b1, LSU_LB,  32'h0000_4001, 32'hFFFF_FF5A, 32'h1234_5678, 1, 0, 1'b0, 4'b0010, 32'h0000_5A00, 32'h0});
        vecs.push_back('{1'b0, LSU_LB,  32'h0000_4002, 32'h0,         32'h007F_0000, 0, 0, 1'b0, 4'b0000, 32'h0,         32'h0000_007F});
        vecs.push_back('{1'b1, LSU_LH,  32'h0000_4000, 32'hAAAA_1234, 32'h0,         0, 3, 1'b0, 4'b0011, 32'h0000_1234, 32'h0});
        vecs.push_back('{1'b1, LSU_LW,  32'h0000_4002, 32'h5555_5555, 32'h0,         0, 0, 1'b1, 4'b0000, 32'h0,         32'h0});
        vecs.push_back('{1'b1, 3'b111,  32'h0000_4000, 32'h5555_5555, 32'h0,         0, 0, 1'b1, 4'b0000, 32'h0,         32'h0});
        vecs.push_back('{1'b0, 3'b110,  32'h0000_4000, 32'h0,         32'h0,         0, 0, 1'b1, 4'b0000, 32'h0,         32'h0});
        // mem_ready low for 5 cycles, mem_rvalid 3 cycles after handshake: response at accept+10.
        vecs.push_back('{1'b1, LSU_LW,  32'h0000_7000, 32'h0F0F_1234, 32'h0,         5, 2, 1'b0, 4'b1111, 32'h0F0F_1234, 32'h0});

        rst        = 1'b1;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_op     = '0;
        req_addr   = '0;
        req_wdata  = '0;
        mem_ready  = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
        @(negedge clk);

        foreach (vecs[i]) do_txn(vecs[i]);

        // Timeout: memory never handshakes; the TIMEOUT=4 instance faults at accept+5,
        // the TIMEOUT=16 instance at accept+17, and a late mem_rvalid is ignored.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        en2 = 1'b1;
        n = cyc;
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_op    = LSU_LW;
        req_addr  = 32'h0000_5000;
        q.push_back('{32'h0, 1'b1, n + 17});
        q2.push_back('{32'h0, 1'b1, n + 5});
        @(negedge clk);
        req_valid = 1'b0;
        for (int k = 1; k <= 18; k++) begin
            if (k <= 4) check("to mem_valid held before timeout", 32'(t_mem_valid), 32'd1);
            if (k == 5) check("to mem_valid dropped at timeout", 32'(t_mem_valid), 32'd0);
            if (k == 6) check("to req_ready after timeout resp", 32'(t_req_ready), 32'd1);
            mem_rvalid = (k == 8);
            mem_rdata  = 32'h1111_2222;
            @(negedge clk);
        end
        mem_rvalid = 1'b0;
        v = '{1'b0, LSU_LW, 32'h0000_5004, 32'h0, 32'h0BAD_F00D, 0, 0, 1'b0, 4'b0000, 32'h0, 32'h0BAD_F00D};
        do_txn(v);
        en2 = 1'b0;

        // Reset while waiting for mem_rvalid abandons the transaction.
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_op    = LSU_LW;
        req_addr  = 32'h0000_6000;
        @(negedge clk);
        req_valid = 1'b0;
        mem_ready = 1'b1;
        check("mem_valid before reset", 32'(mem_valid), 32'd1);
        @(negedge clk);
        mem_ready = 1'b0;
        check("in wait before reset", 32'(mem_valid), 32'd0);
        #1 rst = 1'b1;
        #1 check_reset_outputs("async reset");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h7777_7777;
        @(negedge clk);
        mem_rvalid = 1'b0;
        check("stale rvalid ignored", 32'(resp_valid), 32'd0);
        @(negedge clk);
        v = '{1'b1, LSU_LW, 32'h0000_2000, 32'hDEAD_BEEF, 32'h0, 0, 0, 1'b0, 4'b1111, 32'hDEAD_BEEF, 32'h0};
        do_txn(v);

        repeat (2) @(negedge clk);
        check("idle at end", 32'(req_ready), 32'd1);
        check("dut responses outstanding", 32'(q.size()), 32'd0);
        check("to responses outstanding", 32'(q2.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
